// File: rtl/input_debouncer.sv
// input_debouncer: turns a raw, asynchronous, bouncy input into a clean level.
// The raw input is synchronized first. A four-state FSM then accepts a new
// level only after it has been seen on STABLE_CYCLES consecutive edges.
// Aborted qualifications are tallied in a saturating glitch counter for debug.
module input_debouncer #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16,
    parameter int GLITCH_W      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                a_raw,
    output logic                a_clean,
    output logic                busy,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHECK_HI  = 2'd1,
        STABLE_HI = 2'd2,
        CHECK_LO  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   s;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   a_clean_q;
    logic [GLITCH_W-1:0]    glitch_q;

    // Shift the raw input into the chain; only the chain reads a_raw.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], a_raw};
    assign s      = sync_q[SYNC_STAGES-1];

    // Synchronizer chain against metastability on the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    // Qualification FSM: count consecutive samples of the new level, accept
    // on the last one, and treat any opposite sample as a rejected glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= STABLE_LO;
            cnt_q     <= '0;
            a_clean_q <= 1'b0;
            glitch_q  <= '0;
        end else begin
            case (state_q)
                STABLE_LO: begin
                    if (s) begin
                        state_q <= CHECK_HI;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                CHECK_HI: begin
                    if (!s) begin
                        // An abort on the acceptance cycle is still a glitch.
                        state_q <= STABLE_LO;
                        cnt_q   <= '0;
                        if (glitch_q != '1) glitch_q <= glitch_q + GLITCH_W'(1);
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= STABLE_HI;
                        a_clean_q <= 1'b1;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                STABLE_HI: begin
                    if (!s) begin
                        state_q <= CHECK_LO;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                CHECK_LO: begin
                    if (s) begin
                        state_q <= STABLE_HI;
                        cnt_q   <= '0;
                        if (glitch_q != '1) glitch_q <= glitch_q + GLITCH_W'(1);
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= STABLE_LO;
                        a_clean_q <= 1'b0;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= STABLE_LO;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // busy is decoded from the state register alone, so a_raw has no path to it.
    assign busy       = (state_q == CHECK_HI) || (state_q == CHECK_LO);
    assign a_clean    = a_clean_q;
    assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: directed, table-driven check of the debouncer with
// default parameters, plus a GLITCH_W=3 instance for the saturation case.
// Step i below ends #1 after the i-th rising edge, with edge 1 being the
// first edge that samples the new a_raw level (edge k), so edge k+n is i=n+1.
module tb_input_debouncer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_raw = 1'b0;
    logic       a_raw2 = 1'b0;
    logic       a_clean, busy;
    logic [7:0] glitch_cnt;
    logic       a_clean2, busy2;
    logic [2:0] glitch_cnt2;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic a;
        logic clean;
        logic bsy;
    } vec_t;

    vec_t tbl[40];

    input_debouncer dut (
        .clk(clk), .rst_n(rst_n), .a_raw(a_raw),
        .a_clean(a_clean), .busy(busy), .glitch_cnt(glitch_cnt)
    );

    input_debouncer #(.GLITCH_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .a_raw(a_raw2),
        .a_clean(a_clean2), .busy(busy2), .glitch_cnt(glitch_cnt2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic v);
        a_raw = v;
        @(posedge clk);
        #1;
    endtask

    task automatic step2(input logic v);
        a_raw2 = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        a_raw  = 1'b0;
        a_raw2 = 1'b0;
        rst_n  = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // Fall (a=0) then rise (a=1): busy on i=3..17, a_clean settles at i=18.
        for (int i = 0; i < 20; i++) begin
            tbl[i].a     = 1'b0;
            tbl[i].bsy   = (i + 1 >= 3) && (i + 1 <= 17);
            tbl[i].clean = (i + 1 < 18);
            tbl[20+i].a     = 1'b1;
            tbl[20+i].bsy   = (i + 1 >= 3) && (i + 1 <= 17);
            tbl[20+i].clean = (i + 1 >= 18);
        end

        // Reset held with a_raw toggling: outputs stay at reset values.
        rst_n = 1'b0;
        #1;
        chk("rst_async_clean", a_clean, 0);
        for (int i = 0; i < 6; i++) begin
            step(i[0]);
            chk("rst_clean", a_clean, 0);
            chk("rst_busy", busy, 0);
            chk("rst_glitch", glitch_cnt, 0);
        end

        // Release with a_raw high: full qualification, no shortcut.
        a_raw = 1'b1;
        rst_n = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            step(1'b1);
            chk("rel_clean", a_clean, (i == 18) ? 1 : 0);
            if (i == 2) chk("rel_busy_pre", busy, 0);
            if (i == 3) chk("rel_busy", busy, 1);
        end
        chk("rel_glitch", glitch_cnt, 0);

        // Clean fall then clean rise from the vector table.
        for (int i = 0; i < 40; i++) begin
            step(tbl[i].a);
            chk($sformatf("tbl%0d_clean", i), a_clean, tbl[i].clean);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
        end
        chk("tbl_glitch", glitch_cnt, 0);

        // Bounce: four 3-high/2-low pulses, then high from edge 21 on.
        do_reset();
        for (int i = 1; i <= 45; i++) begin
            logic v;
            v = (i >= 21) || (((i - 1) % 5) < 3);
            step(v);
            chk("bounce_clean", a_clean, (i >= 38) ? 1 : 0);
        end
        chk("bounce_glitch", glitch_cnt, 4);
        chk("bounce_busy", busy, 0);

        // Boundary: exactly 16 high cycles are accepted, then the low is too.
        do_reset();
        for (int i = 1; i <= 36; i++) begin
            step(i <= 16);
            if (i == 17) chk("b16_clean_pre", a_clean, 0);
            if (i == 18) chk("b16_clean_acc", a_clean, 1);
            if (i == 33) chk("b16_clean_hold", a_clean, 1);
            if (i == 34) chk("b16_clean_fall", a_clean, 0);
        end
        chk("b16_glitch", glitch_cnt, 0);

        // Boundary: 15 high cycles abort on the acceptance cycle.
        for (int i = 1; i <= 22; i++) begin
            step(i <= 15);
            chk("b15_clean", a_clean, 0);
            if (i == 17) chk("b15_busy", busy, 1);
            if (i == 18) chk("b15_glitch_land", glitch_cnt, 1);
        end
        chk("b15_glitch", glitch_cnt, 1);
        chk("b15_busy_end", busy, 0);

        // Saturation on the 3-bit instance: 10 single-cycle glitches, period 4.
        do_reset();
        for (int j = 0; j < 10; j++) begin
            for (int p = 0; p < 4; p++) begin
                step2(p == 0);
                chk("sat_clean", a_clean2, 0);
            end
            chk($sformatf("sat_cnt%0d", j), glitch_cnt2, (j + 1 > 7) ? 7 : j + 1);
        end
        for (int i = 0; i < 6; i++) step2(1'b0);
        chk("sat_hold", glitch_cnt2, 7);
        chk("sat_busy", busy2, 0);

        // Reset in the middle of a rising check, then full re-qualification.
        do_reset();
        for (int i = 1; i <= 11; i++) step(1'b1);
        chk("mid_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_busy_async", busy, 0);
        chk("mid_clean_async", a_clean, 0);
        chk("mid_glitch_async", glitch_cnt, 0);
        for (int i = 0; i < 3; i++) step(1'b1);
        rst_n = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            step(1'b1);
            chk("mid_clean", a_clean, (i == 18) ? 1 : 0);
        end
        chk("mid_glitch", glitch_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
